// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the data-memory controller: Funct3 access sizes,
// controller state enum and the default bus timeout.
package riscv_mem_pkg;

   localparam int DEFAULT_TIMEOUT = 255;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DONE
   } mem_state_e;

endpackage

// File: rtl/dmem_ctrl_if.sv
// Data-bus signal bundle between the controller (master) and memory (slave).
interface dmem_ctrl_if;
   logic        bus_valid;
   logic        bus_ready;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_rvalid;

   modport master (
      output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ready, bus_rdata, bus_rvalid
   );

   modport slave (
      input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ready, bus_rdata, bus_rvalid
   );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: byte enables, store-lane replication,
// load shift/extend and misaligned/illegal access detection.
module lsu_align
   import riscv_mem_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic        is_store,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext,
   output logic        bad
);

   logic [31:0] shifted;

   always_comb begin
      be         = 4'b1111;
      wdata_lane = wdata;
      rdata_ext  = '0;
      bad        = 1'b0;
      shifted    = rdata >> {addr_lo, 3'b000};

      // Lanes depend only on size, so loads also get meaningful enables.
      case (funct3[1:0])
         2'b00: begin
            be         = 4'b0001 << addr_lo;
            wdata_lane = {4{wdata[7:0]}};
         end
         2'b01: begin
            be         = 4'b0011 << addr_lo;
            wdata_lane = {2{wdata[15:0]}};
         end
         default: ;
      endcase

      if (is_store) begin
         case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = addr_lo[0];
            F3_W:    bad = |addr_lo;
            default: bad = 1'b1;
         endcase
      end else begin
         case (funct3)
            F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   rdata_ext = {24'h0, shifted[7:0]};
            F3_H: begin
               rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
               bad       = addr_lo[0];
            end
            F3_HU: begin
               rdata_ext = {16'h0, shifted[15:0]};
               bad       = addr_lo[0];
            end
            F3_W: begin
               rdata_ext = shifted;
               bad       = |addr_lo;
            end
            default: bad = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller between the single-cycle RV32I core and a
// valid/ready data bus; stalls the core until each load/store completes.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no access in flight; legal request latched, illegal flagged
// REQ     | bus_valid high, waiting for bus_ready
// WAIT    | read accepted, waiting for bus_rvalid
// DONE    | core retires; ReadData shows the captured (or zeroed) result
module dmem_ctrl
   import riscv_mem_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  Funct3,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        MisalignErr,
   output logic        BusErr,
   dmem_ctrl_if.master bus
);

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   mem_state_e  state, state_nx;
   logic        pending, req_bad, go, capture, expire, timeout_hit;
   logic [3:0]  req_be;
   logic [31:0] req_wdata, rsp_ext;
   logic        valid_q, we_q, buserr_q;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [3:0]  be_q;
   logic [1:0]  addr_lo_q;
   logic [2:0]  f3_q;
   logic [15:0] cnt;

   logic [31:0] req_rdata_unused, rsp_wdata_unused;
   logic [3:0]  rsp_be_unused;
   logic        rsp_bad_unused;

   assign pending     = MemRead | MemWrite;
   assign timeout_hit = (cnt >= CNT_LAST);

   lsu_align u_req_align (
      .addr_lo    (ALUResult[1:0]),
      .funct3     (Funct3),
      .is_store   (MemWrite),
      .wdata      (WriteData),
      .rdata      (32'h0),
      .be         (req_be),
      .wdata_lane (req_wdata),
      .rdata_ext  (req_rdata_unused),
      .bad        (req_bad)
   );

   lsu_align u_rsp_align (
      .addr_lo    (addr_lo_q),
      .funct3     (f3_q),
      .is_store   (1'b0),
      .wdata      (32'h0),
      .rdata      (bus.bus_rdata),
      .be         (rsp_be_unused),
      .wdata_lane (rsp_wdata_unused),
      .rdata_ext  (rsp_ext),
      .bad        (rsp_bad_unused)
   );

   always_comb begin
      state_nx    = state;
      Stall       = 1'b0;
      MisalignErr = 1'b0;
      go          = 1'b0;
      capture     = 1'b0;
      expire      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pending) begin
               if (req_bad) begin
                  MisalignErr = 1'b1;
               end else begin
                  Stall    = 1'b1;
                  go       = 1'b1;
                  state_nx = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            Stall = 1'b1;
            if (bus.bus_ready) begin
               state_nx = we_q ? ST_DONE : ST_WAIT;
            end else if (timeout_hit) begin
               expire   = 1'b1;
               state_nx = ST_DONE;
            end
         end
         ST_WAIT: begin
            Stall = 1'b1;
            if (bus.bus_rvalid) begin
               capture  = 1'b1;
               state_nx = ST_DONE;
            end else if (timeout_hit) begin
               expire   = 1'b1;
               state_nx = ST_DONE;
            end
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         valid_q   <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         addr_lo_q <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         f3_q      <= '0;
         cnt       <= '0;
         rdata_q   <= '0;
         buserr_q  <= 1'b0;
      end else begin
         state    <= state_nx;
         valid_q  <= (state_nx == ST_REQ);
         buserr_q <= expire;
         if (go) begin
            we_q      <= MemWrite;
            addr_q    <= {ALUResult[31:2], 2'b00};
            addr_lo_q <= ALUResult[1:0];
            be_q      <= req_be;
            wdata_q   <= req_wdata;
            f3_q      <= Funct3;
            cnt       <= '0;
            rdata_q   <= '0;
         end else if (state == ST_REQ || state == ST_WAIT) begin
            cnt <= cnt + 16'd1;
         end
         if (capture) rdata_q <= rsp_ext;
         if (expire)  rdata_q <= '0;
      end
   end

   assign bus.bus_valid = valid_q;
   assign bus.bus_we    = we_q;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_be    = be_q;
   assign bus.bus_wdata = wdata_q;

   assign ReadData = (state == ST_DONE) ? rdata_q : 32'h0;
   assign BusErr   = buserr_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed cases plus randomized accesses
// checked against an arithmetic reference model of the load/store rules.
module tb_dmem_ctrl;
   import riscv_mem_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead, MemWrite, MemRead2;
   logic [2:0]  Funct3;
   logic [31:0] ALUResult, WriteData;
   logic [31:0] ReadData, ReadData2;
   logic        Stall, Stall2, MisalignErr, MisalignErr2, BusErr, BusErr2;

   dmem_ctrl_if bus ();
   dmem_ctrl_if bus2 ();

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dmem_ctrl u_dut (
      .clk         (clk),
      .reset       (reset),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .Funct3      (Funct3),
      .ALUResult   (ALUResult),
      .WriteData   (WriteData),
      .ReadData    (ReadData),
      .Stall       (Stall),
      .MisalignErr (MisalignErr),
      .BusErr      (BusErr),
      .bus         (bus)
   );

   dmem_ctrl #(.TIMEOUT(4)) u_dut_to (
      .clk         (clk),
      .reset       (reset),
      .MemRead     (MemRead2),
      .MemWrite    (1'b0),
      .Funct3      (Funct3),
      .ALUResult   (ALUResult),
      .WriteData   (WriteData),
      .ReadData    (ReadData2),
      .Stall       (Stall2),
      .MisalignErr (MisalignErr2),
      .BusErr      (BusErr2),
      .bus         (bus2)
   );

   // observations from the last do_access
   int          o_stall, o_writes;
   bit          o_mis, o_valid_seen, o_berr, o_hung, o_we;
   logic [31:0] o_rd, o_addr, o_wdata;
   logic [3:0]  o_be;

   function automatic int m_size(input logic [2:0] f3);
      return 1 << (f3 % 4);
   endfunction

   function automatic bit m_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
      bit ok;
      if (st) ok = (f3 <= 3'd2);
      else    ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      return ok && ((a % m_size(f3)) == 0);
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
      int v;
      v = ((1 << m_size(f3)) - 1) << (a % 4);
      return 4'(v);
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 4; i++)
         r = r | (((wd >> (8 * (i % m_size(f3)))) & 32'hFF) << (8 * i));
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] rd);
      logic [31:0] v;
      int          s;
      v = rd >> (8 * (a % 4));
      case (f3)
         3'd0:    begin s = $signed(v[7:0]);  return s; end
         3'd1:    begin s = $signed(v[15:0]); return s; end
         3'd4:    return v & 32'hFF;
         3'd5:    return v & 32'hFFFF;
         default: return v;
      endcase
   endfunction

   // Runs one access from just after a posedge; returns after the request drops.
   task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int rlat, input int dlat);
      int vcnt, since;
      bit accepted, fin;
      o_stall = 0; o_writes = 0; o_mis = 0; o_valid_seen = 0; o_berr = 0; o_hung = 0;
      o_we = 0; o_rd = '0; o_addr = '0; o_wdata = '0; o_be = '0;
      MemWrite = st; MemRead = ~st; Funct3 = f3; ALUResult = a; WriteData = wd;
      bus.bus_rdata = rd;
      vcnt = 0; since = 0; accepted = 0; fin = 0;
      for (int c = 0; c < 600 && !fin; c++) begin
         @(negedge clk);
         if (MisalignErr) o_mis = 1;
         if (bus.bus_valid && !o_valid_seen) begin
            o_valid_seen = 1;
            o_addr  = bus.bus_addr;
            o_be    = bus.bus_be;
            o_wdata = bus.bus_wdata;
            o_we    = bus.bus_we;
         end
         if (Stall) o_stall++;
         else begin
            o_rd   = ReadData;
            o_berr = BusErr;
            fin    = 1;
         end
         bus.bus_rvalid = 1'b0;
         if (accepted) begin
            since++;
            bus.bus_rvalid = (since == dlat) && !st;
         end
         bus.bus_ready = bus.bus_valid && (vcnt >= rlat);
         if (bus.bus_valid) vcnt++;
         if (bus.bus_valid && bus.bus_ready) begin
            accepted = 1;
            if (bus.bus_we) o_writes++;
         end
      end
      if (!fin) o_hung = 1;
      @(posedge clk);
      #1;
      MemRead = 0; MemWrite = 0; bus.bus_ready = 0; bus.bus_rvalid = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      total++;
      if ({Stall, MisalignErr, BusErr, bus.bus_valid, bus.bus_we} !== 5'b0) begin
         bad++; $display("FAIL reset_flags got=%b want=00000",
                         {Stall, MisalignErr, BusErr, bus.bus_valid, bus.bus_we});
      end
      total++;
      if ({bus.bus_addr, bus.bus_be, bus.bus_wdata, ReadData} !== '0) begin
         bad++; $display("FAIL reset_regs addr=%h be=%b wdata=%h rd=%h want all 0",
                         bus.bus_addr, bus.bus_be, bus.bus_wdata, ReadData);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_store();
      do_access(1, F3_W, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1);
      total++;
      if (o_be !== 4'b1111 || o_addr !== 32'h100 || o_wdata !== 32'hDEADBEEF || o_we !== 1'b1) begin
         bad++; $display("FAIL sw_bus be=%b addr=%h wdata=%h we=%b want 1111/100/deadbeef/1",
                         o_be, o_addr, o_wdata, o_we);
      end
      total++;
      if (o_stall != 2 || o_writes != 1 || o_hung) begin
         bad++; $display("FAIL sw_timing stall=%0d writes=%0d hung=%0d want 2/1/0",
                         o_stall, o_writes, o_hung);
      end
      do_access(1, F3_B, 32'h103, 32'h000000A5, 32'h0, 0, 1);
      total++;
      if (o_be !== 4'b1000 || o_addr !== 32'h100 || o_wdata !== 32'hA5A5A5A5) begin
         bad++; $display("FAIL sb_bus be=%b addr=%h wdata=%h want 1000/100/a5a5a5a5",
                         o_be, o_addr, o_wdata);
      end
   endtask

   task automatic test_load();
      do_access(0, F3_B, 32'h102, 32'h0, 32'h12F03456, 0, 1);
      total++;
      if (o_rd !== 32'hFFFFFFF0 || o_stall != 3) begin
         bad++; $display("FAIL lb rd=%h stall=%0d want fffffff0/3", o_rd, o_stall);
      end
      do_access(0, F3_BU, 32'h102, 32'h0, 32'h12F03456, 0, 1);
      total++;
      if (o_rd !== 32'h000000F0 || o_stall != 3) begin
         bad++; $display("FAIL lbu rd=%h stall=%0d want 000000f0/3", o_rd, o_stall);
      end
      do_access(0, F3_W, 32'h200, 32'h0, 32'h89ABCDEF, 3, 2);
      total++;
      if (o_rd !== 32'h89ABCDEF || o_stall != 7 || o_addr !== 32'h200 || o_we !== 1'b0) begin
         bad++; $display("FAIL lw_slow rd=%h stall=%0d addr=%h we=%b want 89abcdef/7/200/0",
                         o_rd, o_stall, o_addr, o_we);
      end
   endtask

   task automatic test_misalign();
      do_access(0, F3_H, 32'h101, 32'h0, 32'h55555555, 0, 1);
      total++;
      if (!o_mis || o_valid_seen || o_stall != 0 || o_rd !== 32'h0) begin
         bad++; $display("FAIL lh_misalign mis=%0d valid=%0d stall=%0d rd=%h want 1/0/0/0",
                         o_mis, o_valid_seen, o_stall, o_rd);
      end
      @(negedge clk);
      total++;
      if (MisalignErr !== 1'b0 || bus.bus_valid !== 1'b0) begin
         bad++; $display("FAIL misalign_pulse mis=%b valid=%b want 0/0", MisalignErr, bus.bus_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      bit          st;
      logic [2:0]  f3;
      logic [31:0] a, wd, rd;
      int          rlat, dlat, exp_stall;
      for (int n = 0; n < 60; n++) begin
         st   = bit'($urandom_range(0, 1));
         f3   = 3'($urandom_range(0, 7));
         a    = $urandom;
         wd   = $urandom;
         rd   = $urandom;
         rlat = $urandom_range(0, 3);
         dlat = $urandom_range(1, 3);
         do_access(st, f3, a, wd, rd, rlat, dlat);
         total++;
         if (!m_legal(st, f3, a)) begin
            if (!o_mis || o_valid_seen || o_stall != 0 || o_rd !== 32'h0) begin
               bad++; $display("FAIL rand_illegal st=%0d f3=%0d a=%h mis=%0d valid=%0d stall=%0d rd=%h",
                               st, f3, a, o_mis, o_valid_seen, o_stall, o_rd);
            end
         end else begin
            exp_stall = st ? rlat + 2 : rlat + dlat + 2;
            if (o_mis || o_hung || o_stall != exp_stall || o_addr !== (a & ~32'h3) || o_we !== st) begin
               bad++; $display("FAIL rand_access st=%0d f3=%0d a=%h stall=%0d/%0d addr=%h we=%0d mis=%0d",
                               st, f3, a, o_stall, exp_stall, o_addr, o_we, o_mis);
            end
            total++;
            if (st) begin
               if (o_be !== m_be(f3, a) || o_wdata !== m_wdata(f3, wd) || o_writes != 1) begin
                  bad++; $display("FAIL rand_store f3=%0d a=%h be=%b/%b wdata=%h/%h writes=%0d",
                                  f3, a, o_be, m_be(f3, a), o_wdata, m_wdata(f3, wd), o_writes);
               end
            end else begin
               if (o_rd !== m_load(f3, a, rd) || o_writes != 0) begin
                  bad++; $display("FAIL rand_load f3=%0d a=%h rdata=%h got=%h want=%h",
                                  f3, a, rd, o_rd, m_load(f3, a, rd));
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] pat;
      int         writes;
      MemWrite = 1; Funct3 = F3_W; ALUResult = 32'h10; WriteData = 32'h01234567;
      bus.bus_ready = 1;
      pat = '0; writes = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         pat = {pat[4:0], Stall};
         if (bus.bus_valid && bus.bus_we) writes++;
      end
      @(posedge clk); #1;
      MemWrite = 0; bus.bus_ready = 0;
      total++;
      if (pat !== 6'b110110 || writes != 2) begin
         bad++; $display("FAIL back_to_back stall=%b writes=%0d want 110110/2", pat, writes);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_timeout();
      int vcnt, scnt;
      bit fin;
      logic [31:0] rd_done;
      logic        be_done;
      bus2.bus_ready = 0; bus2.bus_rvalid = 0; bus2.bus_rdata = 32'hFFFF0000;
      Funct3 = F3_W; ALUResult = 32'h40; MemRead2 = 1;
      vcnt = 0; scnt = 0; fin = 0; rd_done = 'x; be_done = 0;
      for (int c = 0; c < 40 && !fin; c++) begin
         @(negedge clk);
         if (bus2.bus_valid) vcnt++;
         if (Stall2) scnt++;
         else begin
            fin = 1; rd_done = ReadData2; be_done = BusErr2;
         end
      end
      @(posedge clk); #1;
      MemRead2 = 0;
      total++;
      if (!fin || vcnt != 4 || scnt != 5) begin
         bad++; $display("FAIL timeout_len done=%0d valid_cycles=%0d stall=%0d want 1/4/5",
                         fin, vcnt, scnt);
      end
      total++;
      if (be_done !== 1'b1 || rd_done !== 32'h0) begin
         bad++; $display("FAIL timeout_err buserr=%b rd=%h want 1/0", be_done, rd_done);
      end
      @(negedge clk);
      total++;
      if (BusErr2 !== 1'b0 || bus2.bus_valid !== 1'b0 || Stall2 !== 1'b0) begin
         bad++; $display("FAIL timeout_after buserr=%b valid=%b stall=%b want 0/0/0",
                         BusErr2, bus2.bus_valid, Stall2);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bit ok;
      MemRead = 1; Funct3 = F3_W; ALUResult = 32'h300; bus.bus_rdata = 32'hCAFEF00D;
      @(negedge clk);
      @(negedge clk);
      bus.bus_ready = bus.bus_valid;
      @(negedge clk);
      bus.bus_ready = 0;
      total++;
      if (Stall !== 1'b1 || bus.bus_valid !== 1'b0) begin
         bad++; $display("FAIL reset_mid_wait stall=%b valid=%b want 1/0", Stall, bus.bus_valid);
      end
      @(posedge clk); #1;
      reset = 1; MemRead = 0;
      @(posedge clk); #1;
      reset = 0; bus.bus_rvalid = 1;
      ok = 1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (Stall !== 1'b0 || bus.bus_valid !== 1'b0 || ReadData !== 32'h0) ok = 0;
         bus.bus_rvalid = 0;
      end
      total++;
      if (!ok) begin
         bad++; $display("FAIL reset_mid_after stall=%b valid=%b rd=%h want 0/0/0",
                         Stall, bus.bus_valid, ReadData);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1; MemRead = 0; MemWrite = 0; MemRead2 = 0;
      Funct3 = '0; ALUResult = '0; WriteData = '0;
      bus.bus_ready = 0; bus.bus_rvalid = 0; bus.bus_rdata = '0;
      bus2.bus_ready = 0; bus2.bus_rvalid = 0; bus2.bus_rdata = '0;
      test_reset();
      test_store();
      test_load();
      test_misalign();
      test_random();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
